// File: rtl/segre_pkg.sv
// Shared types for the segre memory subsystem: cache/memory request format,
// cache identifiers and the arbiter's buffer sizing and FSM states.
package segre_pkg;

  localparam int unsigned ADDR_SIZE            = 32;
  localparam int unsigned CACHE_LINE_SIZE_BITS = 128;
  localparam int unsigned ARB_BUF_SIZE         = 16;
  localparam int unsigned ARB_PTR_SIZE         = $clog2(ARB_BUF_SIZE);

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } cache_id_e;

  typedef struct packed {
    logic [ADDR_SIZE-1:0]            addr;
    logic                            rd;
    logic                            wr;
    logic [CACHE_LINE_SIZE_BITS-1:0] data;
    cache_id_e                       cache_id;
  } cache_mem_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

  // Round-robin helper: the requester that was not served last time.
  function automatic cache_id_e rr_other(input cache_id_e last);
    return (last == ICACHE) ? DCACHE : ICACHE;
  endfunction

endpackage

// File: rtl/segre_arb_fifo.sv
// Generic single-push/single-pop FIFO; storage is not reset, only pointers and count.
// DEPTH must be a power of two (>= 2) so the pointers wrap by natural overflow.
module segre_arb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign data_o  = mem[rd_ptr];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/segre_mem_arbiter.sv
// Arbitrates icache/dcache miss and writeback requests into an in-order queue and
// issues them to main memory one at a time, routing each response back by cache_id.
module segre_mem_arbiter
  import segre_pkg::*;
#(
  parameter int unsigned BUF_SIZE = ARB_BUF_SIZE,
  parameter int unsigned PTR_SIZE = $clog2(BUF_SIZE)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            icache_req_valid_i,
  input  cache_mem_req_t                  icache_req_i,
  output logic                            icache_req_ready_o,
  input  logic                            dcache_req_valid_i,
  input  cache_mem_req_t                  dcache_req_i,
  output logic                            dcache_req_ready_o,
  output logic                            mem_req_valid_o,
  output cache_mem_req_t                  mem_req_o,
  input  logic                            mem_req_ready_i,
  input  logic                            mem_rsp_valid_i,
  input  logic [CACHE_LINE_SIZE_BITS-1:0] mem_rsp_data_i,
  output logic                            icache_rsp_valid_o,
  output logic                            dcache_rsp_valid_o,
  output logic [CACHE_LINE_SIZE_BITS-1:0] rsp_data_o
);

  arb_state_e     state;
  arb_state_e     state_d;
  cache_id_e      last_grant;
  logic           grant_i;
  logic           grant_d;
  logic           push;
  logic           pop;
  logic           capture;
  logic           fifo_full;
  logic           fifo_empty;
  logic [PTR_SIZE:0] count;
  cache_mem_req_t push_req;
  cache_mem_req_t head;

  // Grant looks only at the registered occupancy, so a pop this cycle never
  // frees a slot for a push in the same cycle.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst_i && !fifo_full) begin
      if (icache_req_valid_i && dcache_req_valid_i) begin
        grant_i = (rr_other(last_grant) == ICACHE);
        grant_d = (rr_other(last_grant) == DCACHE);
      end else begin
        grant_i = icache_req_valid_i;
        grant_d = dcache_req_valid_i;
      end
    end
  end

  assign icache_req_ready_o = grant_i;
  assign dcache_req_ready_o = grant_d;
  assign push               = grant_i || grant_d;
  assign push_req           = grant_d ? dcache_req_i : icache_req_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant <= ICACHE;
    end else if (grant_i) begin
      last_grant <= ICACHE;
    end else if (grant_d) begin
      last_grant <= DCACHE;
    end
  end

  segre_arb_fifo #(
    .WIDTH ($bits(cache_mem_req_t)),
    .DEPTH (BUF_SIZE)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_req),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d            = state;
    mem_req_valid_o    = 1'b0;
    icache_rsp_valid_o = 1'b0;
    dcache_rsp_valid_o = 1'b0;
    pop                = 1'b0;
    capture            = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (count != '0) state_d = ARB_REQ;
      end
      ARB_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mem_rsp_valid_i) begin
          capture = 1'b1;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        pop                = !fifo_empty;
        icache_rsp_valid_o = (head.cache_id == ICACHE);
        dcache_rsp_valid_o = (head.cache_id == DCACHE);
        state_d            = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Head is only presented while the request is live; storage is unreset.
  assign mem_req_o = mem_req_valid_o ? head : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_data_o <= '0;
    end else if (capture) begin
      rsp_data_o <= mem_rsp_data_i;
    end
  end

  a_one_grant : assert property (@(posedge clk_i) disable iff (rst_i)
    !(icache_req_ready_o && dcache_req_ready_o));

  a_req_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (mem_req_valid_o && !mem_req_ready_i) |=> (mem_req_valid_o && $stable(mem_req_o)));

  a_one_rsp : assert property (@(posedge clk_i) disable iff (rst_i)
    !(icache_rsp_valid_o && dcache_rsp_valid_o));

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed and randomized bench for segre_mem_arbiter with a transaction-level
// reference model (queue + latency rules) checked every cycle.
module tb_segre_mem_arbiter;
  import segre_pkg::*;

  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst_i;
  logic           iv, dv;
  cache_mem_req_t ireq, dreq;
  logic           iready, dready;
  logic           mem_req_valid_o;
  cache_mem_req_t mem_req_o;
  logic           mem_req_ready_i;
  logic           mem_rsp_valid_i;
  logic [127:0]   mem_rsp_data_i;
  logic           irsp, drsp;
  logic [127:0]   rsp_data_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  segre_mem_arbiter #(.BUF_SIZE(DEPTH)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .icache_req_valid_i (iv),
    .icache_req_i       (ireq),
    .icache_req_ready_o (iready),
    .dcache_req_valid_i (dv),
    .dcache_req_i       (dreq),
    .dcache_req_ready_o (dready),
    .mem_req_valid_o    (mem_req_valid_o),
    .mem_req_o          (mem_req_o),
    .mem_req_ready_i    (mem_req_ready_i),
    .mem_rsp_valid_i    (mem_rsp_valid_i),
    .mem_rsp_data_i     (mem_rsp_data_i),
    .icache_rsp_valid_o (irsp),
    .dcache_rsp_valid_o (drsp),
    .rsp_data_o         (rsp_data_o)
  );

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic cache_mem_req_t rand_req(input cache_id_e id);
    cache_mem_req_t r;
    r.addr     = $urandom & 32'hFFFF_FFF0;
    r.wr       = (id == DCACHE) ? 1'($urandom_range(0, 1)) : 1'b0;
    r.rd       = !r.wr;
    r.data     = {$urandom, $urandom, $urandom, $urandom};
    r.cache_id = id;
    return r;
  endfunction

  // Reference model: queued requests with acceptance cycle; a request is
  // presented 2 cycles after acceptance or after the previous response.
  typedef struct {
    cache_mem_req_t req;
    int             acc;
  } ent_t;

  ent_t         q[$];
  cache_id_e    m_last = ICACHE;
  bit           m_out = 0;
  int           m_wait_from = 0;
  int           m_resp_due = -1;
  int           m_last_resp = -100;
  logic [127:0] m_data = '0;
  int           t = 0;
  logic         e_gi, e_gd, e_mv, e_resp, e_ri, e_rd;

  always @(negedge clk) begin
    t = t + 1;
    if (rst_i) begin
      check("rst_iready", iready, 1'b0);
      check("rst_dready", dready, 1'b0);
      check("rst_mem_valid", mem_req_valid_o, 1'b0);
      check("rst_irsp", irsp, 1'b0);
      check("rst_drsp", drsp, 1'b0);
      check("rst_rsp_data", rsp_data_o, 128'h0);
      q.delete();
      m_last      = ICACHE;
      m_out       = 0;
      m_resp_due  = -1;
      m_last_resp = -100;
    end else begin
      e_gi = 1'b0;
      e_gd = 1'b0;
      if (q.size() < DEPTH) begin
        if (iv && dv) begin
          if (m_last == ICACHE) e_gd = 1'b1;
          else                  e_gi = 1'b1;
        end else begin
          e_gi = iv;
          e_gd = dv;
        end
      end
      check("m_iready", iready, e_gi);
      check("m_dready", dready, e_gd);

      e_mv = (q.size() > 0) && !m_out && (t >= q[0].acc + 2) && (t >= m_last_resp + 2);
      check("m_mem_valid", mem_req_valid_o, e_mv);
      if (e_mv) check("m_mem_req", mem_req_o, q[0].req);

      e_resp = m_out && (m_resp_due == t);
      e_ri   = e_resp && (q[0].req.cache_id == ICACHE);
      e_rd   = e_resp && (q[0].req.cache_id == DCACHE);
      check("m_irsp", irsp, e_ri);
      check("m_drsp", drsp, e_rd);
      if (e_resp && !q[0].req.wr) check("m_rsp_data", rsp_data_o, m_data);

      if (m_out && m_resp_due < 0 && t >= m_wait_from && mem_rsp_valid_i) begin
        m_resp_due = t + 1;
        m_data     = mem_rsp_data_i;
      end
      if (e_resp) begin
        void'(q.pop_front());
        m_out       = 0;
        m_resp_due  = -1;
        m_last_resp = t;
      end
      if (e_mv && mem_req_ready_i) begin
        m_out       = 1;
        m_wait_from = t + 1;
      end
      if (e_gi) begin
        q.push_back('{req: ireq, acc: t});
        m_last = ICACHE;
      end
      if (e_gd) begin
        q.push_back('{req: dreq, acc: t});
        m_last = DCACHE;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n, input string nm);
    int got;
    got = 0;
    mem_req_ready_i = 1'b1;
    mem_rsp_valid_i = 1'b1;
    for (int k = 0; k < 400 && got < n; k++) begin
      @(negedge clk);
      if (irsp || drsp) got++;
      next_cycle();
      mem_rsp_data_i = {$urandom, $urandom, $urandom, $urandom};
    end
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    check(nm, got, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] LINE1 = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] LINE2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  initial begin
    cache_id_e gexp [4];
    int        got, acc;
    logic      i_f, d_f;

    rst_i = 1'b1;
    iv = 1'b1; dv = 1'b1;
    ireq = rand_req(ICACHE);
    dreq = rand_req(DCACHE);
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_iready", iready, 1'b0);
    check("reset_dready", dready, 1'b0);
    check("reset_mem_valid", mem_req_valid_o, 1'b0);
    check("reset_rsp_data", rsp_data_o, 128'h0);
    next_cycle();
    rst_i = 1'b0; iv = 1'b0; dv = 1'b0;
    next_cycle();

    // Single icache read, minimum latency.
    iv = 1'b1;
    ireq = '{addr: 32'h0000_1000, rd: 1'b1, wr: 1'b0, data: '0, cache_id: ICACHE};
    @(negedge clk); check("t1_accept", iready, 1'b1);
    next_cycle(); iv = 1'b0;
    @(negedge clk); check("t1_c1_mem_valid", mem_req_valid_o, 1'b0);
    next_cycle(); mem_req_ready_i = 1'b1;
    @(negedge clk);
    check("t1_c2_mem_valid", mem_req_valid_o, 1'b1);
    check("t1_c2_addr", mem_req_o.addr, 32'h1000);
    check("t1_c2_rd", mem_req_o.rd, 1'b1);
    next_cycle(); mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rsp_data_i = LINE1;
    @(negedge clk); check("t1_c3_irsp", irsp, 1'b0);
    next_cycle(); mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    check("t1_c4_irsp", irsp, 1'b1);
    check("t1_c4_drsp", drsp, 1'b0);
    check("t1_c4_data", rsp_data_o, LINE1);
    next_cycle();
    @(negedge clk); check("t1_c5_irsp", irsp, 1'b0);
    next_cycle();

    // Both caches valid: round-robin starting with dcache.
    gexp = '{DCACHE, ICACHE, DCACHE, ICACHE};
    iv = 1'b1; ireq = rand_req(ICACHE);
    dv = 1'b1; dreq = rand_req(DCACHE);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_grant_d", dready, gexp[k] == DCACHE);
      check("t2_grant_i", iready, gexp[k] == ICACHE);
      next_cycle();
      if (gexp[k] == DCACHE) dreq = rand_req(DCACHE);
      else                   ireq = rand_req(ICACHE);
    end
    iv = 1'b0; dv = 1'b0;
    got = 0;
    mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b1;
    for (int k = 0; k < 200 && got < 4; k++) begin
      @(negedge clk);
      if (irsp || drsp) begin
        check("t2_rsp_route", drsp, gexp[got] == DCACHE);
        got++;
      end
      next_cycle();
    end
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
    check("t2_rsp_count", got, 4);

    // Fill to capacity, then release memory and wrap pointers.
    dv = 1'b1; dreq = rand_req(DCACHE);
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk); check("t3_fill_ready", dready, 1'b1);
      next_cycle(); dreq = rand_req(DCACHE);
    end
    @(negedge clk);
    check("t3_full_ready", dready, 1'b0);
    check("t3_count", dut.count, DEPTH);
    next_cycle();
    acc = DEPTH; got = 0;
    mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b1;
    for (int k = 0; k < 600 && got < DEPTH + 4; k++) begin
      @(negedge clk);
      d_f = dv && dready;
      if (d_f) acc++;
      if (irsp || drsp) got++;
      next_cycle();
      mem_rsp_data_i = {$urandom, $urandom, $urandom, $urandom};
      if (d_f) begin
        if (acc < DEPTH + 4) dreq = rand_req(DCACHE);
        else                 dv = 1'b0;
      end
    end
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
    check("t3_accepted", acc, DEPTH + 4);
    check("t3_responses", got, DEPTH + 4);
    next_cycle();

    // dcache write with ack 5 cycles after acceptance.
    dv = 1'b1;
    dreq = '{addr: 32'h0000_2040, rd: 1'b0, wr: 1'b1, data: LINE2, cache_id: DCACHE};
    @(negedge clk); check("t4_accept", dready, 1'b1);
    next_cycle(); dv = 1'b0;
    next_cycle(); mem_req_ready_i = 1'b1;
    @(negedge clk);
    check("t4_mem_valid", mem_req_valid_o, 1'b1);
    check("t4_wr", mem_req_o.wr, 1'b1);
    check("t4_addr", mem_req_o.addr, 32'h2040);
    check("t4_line", mem_req_o.data, LINE2);
    next_cycle(); mem_req_ready_i = 1'b0;
    @(negedge clk); check("t4_c3_drsp", drsp, 1'b0);
    next_cycle();
    @(negedge clk); check("t4_c4_drsp", drsp, 1'b0);
    next_cycle(); mem_rsp_valid_i = 1'b1;
    @(negedge clk); check("t4_c5_drsp", drsp, 1'b0);
    next_cycle(); mem_rsp_valid_i = 1'b0;
    @(negedge clk); check("t4_c6_drsp", drsp, 1'b1); check("t4_c6_irsp", irsp, 1'b0);
    next_cycle();
    @(negedge clk); check("t4_c7_drsp", drsp, 1'b0);
    next_cycle();

    // Spurious responses in IDLE and REQ.
    mem_rsp_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t5_idle_pulse", {irsp, drsp}, 2'b00);
      check("t5_idle_mem_valid", mem_req_valid_o, 1'b0);
      next_cycle();
    end
    iv = 1'b1; ireq = rand_req(ICACHE);
    @(negedge clk); check("t5_accept", iready, 1'b1);
    next_cycle(); iv = 1'b0;
    for (int k = 1; k < 7; k++) begin
      @(negedge clk);
      check("t5_req_pulse", {irsp, drsp}, 2'b00);
      if (k >= 2) check("t5_req_held", mem_req_valid_o, 1'b1);
      next_cycle();
    end
    mem_rsp_valid_i = 1'b0;
    drain(1, "t5_drain");

    // Reset while WAIT with three entries queued.
    dv = 1'b1; dreq = rand_req(DCACHE);
    @(negedge clk); check("t6_acc0", dready, 1'b1);
    next_cycle(); dreq = rand_req(DCACHE);
    @(negedge clk); check("t6_acc1", dready, 1'b1);
    next_cycle(); dreq = rand_req(DCACHE); mem_req_ready_i = 1'b1;
    @(negedge clk); check("t6_acc2", dready, 1'b1);
    next_cycle(); dv = 1'b0; mem_req_ready_i = 1'b0;
    @(negedge clk); check("t6_count_before", dut.count, 3);
    next_cycle(); rst_i = 1'b1; iv = 1'b1; ireq = rand_req(ICACHE);
    @(negedge clk);
    check("t6_rst_iready", iready, 1'b0);
    check("t6_rst_mem_valid", mem_req_valid_o, 1'b0);
    check("t6_rst_mem_req", mem_req_o, '0);
    check("t6_rst_pulse", {irsp, drsp}, 2'b00);
    check("t6_rst_data", rsp_data_o, 128'h0);
    next_cycle(); rst_i = 1'b0; iv = 1'b0; mem_rsp_valid_i = 1'b1;
    @(negedge clk);
    check("t6_count_after", dut.count, 0);
    check("t6_late_pulse", {irsp, drsp}, 2'b00);
    check("t6_after_mem_valid", mem_req_valid_o, 1'b0);
    next_cycle();
    @(negedge clk); check("t6_late_pulse2", {irsp, drsp}, 2'b00);
    next_cycle(); mem_rsp_valid_i = 1'b0;
    iv = 1'b1; ireq = rand_req(ICACHE);
    @(negedge clk); check("t6_new_accept", iready, 1'b1);
    next_cycle(); iv = 1'b0;
    drain(1, "t6_drain");

    // Randomized traffic with one mid-run reset.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      i_f = iv && iready;
      d_f = dv && dready;
      next_cycle();
      rst_i = (c >= 2000 && c < 2003);
      if (!iv || i_f) begin
        iv   = ($urandom_range(0, 99) < 35);
        ireq = rand_req(ICACHE);
      end
      if (!dv || d_f) begin
        dv   = ($urandom_range(0, 99) < 45);
        dreq = rand_req(DCACHE);
      end
      mem_req_ready_i = ($urandom_range(0, 99) < 60);
      mem_rsp_valid_i = ($urandom_range(0, 99) < 40);
      mem_rsp_data_i  = {$urandom, $urandom, $urandom, $urandom};
    end
    rst_i = 1'b0; iv = 1'b0; dv = 1'b0;
    mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b1;
    repeat (120) next_cycle();
    @(negedge clk);
    check("final_mem_valid", mem_req_valid_o, 1'b0);
    check("final_count", dut.count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
